// File: rtl/mem_requester_pkg.sv
// rtl/mem_requester_pkg.sv - shared width codes, size codes, FSM encoding and command helpers
// Contents: funct3 codes (F3_*), one-hot size codes (BHW_*), timeout counter width,
//           requester state encoding, legality / size / store-data helper functions.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] BHW_B = 3'b001;
    localparam logic [2:0] BHW_H = 3'b010;
    localparam logic [2:0] BHW_W = 3'b100;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Encoding and alignment in one place so the FSM only sees a single go/no-go bit.
    function automatic logic cmd_legal(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic enc_ok;
        logic align_ok;
        case (funct3)
            F3_B, F3_H, F3_W: enc_ok = 1'b1;
            F3_BU, F3_HU:     enc_ok = ~is_store;
            default:          enc_ok = 1'b0;
        endcase
        case (funct3)
            F3_H, F3_HU: align_ok = ~addr_lo[0];
            F3_W:        align_ok = (addr_lo == 2'b00);
            default:     align_ok = 1'b1;
        endcase
        return enc_ok & align_ok;
    endfunction

    function automatic logic [2:0] bhw_of(input logic [2:0] funct3);
        logic [2:0] bhw;
        case (funct3)
            F3_B, F3_BU: bhw = BHW_B;
            F3_H, F3_HU: bhw = BHW_H;
            default:     bhw = BHW_W;
        endcase
        return bhw;
    endfunction

    // Memory expects the bytes above the access size to be zero.
    function automatic logic [31:0] store_data(input logic [2:0]  funct3,
                                               input logic [31:0] wdata);
        logic [31:0] d;
        case (funct3)
            F3_B:    d = {24'h0, wdata[7:0]};
            F3_H:    d = {16'h0, wdata[15:0]};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_requester_if.sv
// rtl/mem_requester_if.sv - requester-to-main-memory bus
// Signals: request (one-cycle access strobe), bhw (one-hot size), WR_nRD (1 write / 0 read),
//          ADR (byte address), DATA (store data), DATAOUT (read data), send (acknowledge).
// Modports: master = requester side, slave = memory side.
interface mem_requester_if;
    logic        request;
    logic [2:0]  bhw;
    logic        WR_nRD;
    logic [31:0] ADR;
    logic [31:0] DATA;
    logic [31:0] DATAOUT;
    logic        send;

    modport master (output request, bhw, WR_nRD, ADR, DATA,
                    input  DATAOUT, send);
    modport slave  (input  request, bhw, WR_nRD, ADR, DATA,
                    output DATAOUT, send);
endinterface

// File: rtl/mem_requester_load_extend.sv
// rtl/mem_requester_load_extend.sv - sign/zero extension of raw load data by width code
// Ports: funct3 (width code), raw (right-aligned memory data, upper bytes may be junk),
//        ext (extended 32-bit load result).
module load_extend
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   ext = {24'h0, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_requester.sv
// rtl/mem_requester.sv - single-outstanding load/store initiator toward main memory
// Ports: CLK, RST (sync, active-high); command: start, is_store, funct3, addr, wdata;
//        response: rdata, done, err, busy; mem: mem_requester_if master modport.
module mem_requester
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    mem_requester_if.master       mem
);

    localparam logic [CNT_W:0] TO_LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             cnt_at_limit;

    logic [2:0]       funct3_q;
    logic             wr_q;
    logic [31:0]      adr_q;
    logic [31:0]      data_q;
    logic [2:0]       bhw_q;
    logic             err_q;
    logic [31:0]      rdata_q;
    logic [31:0]      ext_data;

    logic             accept;
    logic             reject;
    logic             ack;
    logic             expire;

    load_extend u_load_extend (
        .funct3 (funct3_q),
        .raw    (mem.DATAOUT),
        .ext    (ext_data)
    );

    // cnt counts completed WAIT cycles; the cycle in which it would reach the limit is the last one.
    assign cnt_inc      = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_at_limit = (cnt_inc == TO_LIMIT);

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        reject  = 1'b0;
        ack     = 1'b0;
        expire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cmd_legal(is_store, funct3, addr[1:0])) begin
                        accept  = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        reject  = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // An acknowledge in the final counted cycle still wins over the timeout.
                if (mem.send) begin
                    ack     = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_at_limit) begin
                    expire  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            funct3_q <= '0;
            wr_q     <= 1'b0;
            adr_q    <= '0;
            data_q   <= '0;
            bhw_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state <= state_d;

            if (state == ST_WAIT && state_d == ST_WAIT) begin
                cnt <= cnt_inc[CNT_W-1:0];
            end else begin
                cnt <= '0;
            end

            // Bus fields hold from ISSUE through WAIT and are zero otherwise.
            if (accept) begin
                funct3_q <= funct3;
                wr_q     <= is_store;
                adr_q    <= addr;
                bhw_q    <= bhw_of(funct3);
                data_q   <= is_store ? store_data(funct3, wdata) : 32'h0;
            end else if (state_d == ST_IDLE || state_d == ST_RESP) begin
                wr_q   <= 1'b0;
                adr_q  <= '0;
                bhw_q  <= '0;
                data_q <= '0;
            end

            // Both are only non-zero during the single RESP cycle that follows.
            err_q   <= reject | expire;
            rdata_q <= (ack && !wr_q) ? ext_data : 32'h0;
        end
    end

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_RESP);
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign mem.request = (state == ST_ISSUE);
    assign mem.bhw     = bhw_q;
    assign mem.WR_nRD  = wr_q;
    assign mem.ADR     = adr_q;
    assign mem.DATA    = data_q;

endmodule

// File: doc/mem_requester.md
# mem_requester

Initiator side of the CPU-to-main-memory byte/half/word protocol. Accepts one load or store per command from the execute stage, checks alignment and encoding, and drives exactly one `request` cycle toward main memory. It then waits for the `send` acknowledge, sign- or zero-extends load data and reports completion or error. It sits between the core's execute/memory stage and `mainMemory`.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles to wait in WAIT for `send` before aborting with error (1..255).
- `CLK` in 1: single clock, all logic on rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `start` in 1: command strobe, sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `rdata` out 32: extended load result, valid while `done`=1.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; misaligned, illegal funct3 or timeout.
- `busy` out 1: high in any state except IDLE.
- `request` out 1: memory request, high for exactly one cycle per access.
- `bhw` out 3: one-hot size, 001 byte, 010 half, 100 word.
- `WR_nRD` out 1: 1 write, 0 read.
- `ADR` out 32: memory address.
- `DATA` out 32: store data, masked to size with upper bytes zero.
- `DATAOUT` in 32: memory read data, valid in the `send` cycle.
- `send` in 1: memory acknowledge pulse.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On `start`, latch `is_store`, `funct3`, `addr` and `wdata`.
  - Legal and aligned: go to ISSUE.
  - Otherwise: go to RESP with `err`=1 and no memory access.
- Legality rules:
  - Loads accept funct3 000, 001, 010, 100, 101.
  - Stores accept 000, 001, 010.
  - Half requires `addr[0]`=0. Word requires `addr[1:0]`=00.
- ISSUE: assert `request` for one cycle, then go to WAIT. Memory repeats the access on every cycle `request` is high, so it must never be held high.
- WAIT:
  - On `send`=1, capture `DATAOUT` and go to RESP.
  - The timeout counter starts at 0 on WAIT entry. When it reaches `TIMEOUT_CYCLES` with no `send`, go to RESP with `err`=1.
- RESP: `done`=1 for one cycle, then return to IDLE.
- Load extension:
  - B: sign-extend bit 7. BU: zero-extend the byte.
  - H: sign-extend bit 15. HU: zero-extend the half.
  - W: pass through.
- Stores: `rdata`=0. On error: `rdata`=0.
- `ADR`, `bhw`, `WR_nRD` and `DATA` are registered from the latched command and stay stable from ISSUE through WAIT. They are 0 in IDLE.

## Timing
- Reset values: `request`=0, `done`=0, `err`=0, `busy`=0, `rdata`=0, `ADR`=0, `DATA`=0, `bhw`=000, `WR_nRD`=0. State IDLE, counter 0.
- Cycle numbering for a legal access:
  - `start` is sampled at edge 0.
  - `request`=1 during cycle 1.
  - Memory samples at edge 1. `send` is expected in cycle 2 or later.
  - `done` follows the `send` cycle by exactly one cycle.
- Minimum command-to-done latency is 3 cycles. An illegal command gives `done` 1 cycle after `start`.
- `start` while `busy`=1 is ignored and is not queued.
- A `send` arriving in IDLE, ISSUE or RESP is ignored, including a late acknowledge after a timeout.
- `RST` asserted in any state returns to IDLE on the next edge. `request` drops the same edge and no `done` is emitted.
- `send` in the same cycle the timeout count is reached counts as success.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after RESP.

## Structure
- Shared package `mem_pkg` holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - bhw constants: BHW_B=001, BHW_H=010, BHW_W=100.
  - State encoding.
- One combinational sub-module, `load_extend`, maps (funct3, raw 32-bit data) to the extended 32-bit result. It is reusable by the core's bypass path.
- The counter width is 8 bits, fixed by the `TIMEOUT_CYCLES` range.

## Test plan
- Store word 0xDEADBEEF to 0x100, then load word from 0x100 → `request`=1 for exactly one cycle with `bhw`=100 and `WR_nRD`=1. The load then returns `rdata`=0xDEADBEEF with `err`=0.
- Memory byte at 0x104=0x80 → LB returns 0xFFFFFF80; LBU returns 0x00000080.
- Half at 0x106=0x8001 → LH returns 0xFFFF8001; LHU returns 0x00008001.
- LW from 0x102, and a store with funct3=100 → no `request`. Both give `done`=1 and `err`=1 one cycle after `start`.
- Responder withholds `send` → `done`=1 and `err`=1 exactly TIMEOUT_CYCLES+1 cycles after `request`. A later `send` is ignored and `busy`=0.
- `RST` pulsed during WAIT, and `start` pulsed while `busy`=1 → after reset, IDLE with all outputs at 0 and no `done`. The start issued while busy produces no second `request`.
